// File: rtl/data_bus_responder.sv
// Data-side RV32I bus responder: byte-laned RAM plus peripheral window, sticky error flag/counter.
// Loads complete 2 cycles after the request; one request per cycle, no backpressure.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic [31:0] addr,
  input  logic [31:0] dataBusIn,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [3:0]  RamMode,
  output logic [31:0] dataBusOut,
  output logic        dataBusOutEn,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_wdata,
  output logic [3:0]  periph_be,
  output logic        periph_wrEn,
  output logic        periph_rdEn,
  input  logic [31:0] periph_rdata,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [7:0]  err_cnt
);
  localparam int AW = $clog2(RAM_WORDS);

  logic          w_is_byte, w_is_half, w_is_word, w_uns;
  logic          w_mode_ok, w_misaligned, w_in_periph, w_in_ram;
  logic          w_access_bad, w_req, w_err, w_rd, w_ram_wr;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;

  assign w_is_byte    = RamMode[3];
  assign w_is_half    = RamMode[2];
  assign w_is_word    = RamMode[1];
  assign w_uns        = RamMode[0];
  assign w_mode_ok    = (RamMode[3:1] == 3'b100) || (RamMode[3:1] == 3'b010) ||
                        (RamMode[3:1] == 3'b001);
  assign w_misaligned = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));
  assign w_in_periph  = (addr & PERIPH_MASK) == PERIPH_BASE;
  assign w_in_ram     = !w_in_periph && (addr[31:AW+2] == '0);
  assign w_idx        = addr[AW+1:2];

  assign w_access_bad = !w_mode_ok || w_misaligned || (!w_in_periph && !w_in_ram);
  assign w_req        = wrEn || rdEn;
  // A simultaneous read+write is an error, but the write still goes ahead.
  assign w_err        = w_req && (w_access_bad || (wrEn && rdEn));
  assign w_rd         = rdEn && !wrEn;
  assign w_ram_wr     = rstB && wrEn && !w_access_bad && w_in_ram;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = dataBusIn;
    if (w_is_byte) begin
      w_be    = 4'b0001 << addr[1:0];
      w_wdata = {4{dataBusIn[7:0]}};
    end else if (w_is_half) begin
      w_be    = addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{dataBusIn[15:0]}};
    end
  end

  assign periph_addr  = addr;
  assign periph_wdata = w_wdata;
  assign periph_be    = w_be;
  assign periph_wrEn  = rstB && wrEn && !w_access_bad && w_in_periph;
  assign periph_rdEn  = rstB && w_rd && !w_access_bad && w_in_periph;

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_ram_q;

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
    if (w_rd) r_ram_q <= r_mem[w_idx];
  end

  logic       r_s1_vld, r_s1_err, r_s1_periph, r_s1_byte, r_s1_half, r_s1_uns;
  logic [1:0] r_s1_off;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      r_s1_vld    <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_periph <= 1'b0;
      r_s1_byte   <= 1'b0;
      r_s1_half   <= 1'b0;
      r_s1_uns    <= 1'b0;
      r_s1_off    <= 2'b00;
    end else begin
      r_s1_vld    <= w_rd;
      r_s1_err    <= w_access_bad;
      r_s1_periph <= w_in_periph;
      r_s1_byte   <= w_is_byte;
      r_s1_half   <= w_is_half;
      r_s1_uns    <= w_uns;
      r_s1_off    <= addr[1:0];
    end
  end

  logic [31:0] w_word, w_shift, w_load;

  always_comb begin
    w_word  = r_s1_periph ? periph_rdata : r_ram_q;
    w_shift = w_word >> {r_s1_off, 3'b000};
    w_load  = w_word;
    if (r_s1_byte) begin
      w_load = {{24{!r_s1_uns && w_shift[7]}}, w_shift[7:0]};
    end else if (r_s1_half) begin
      w_load = {{16{!r_s1_uns && w_shift[15]}}, w_shift[15:0]};
    end
    if (r_s1_err) w_load = '0;
  end

  logic [31:0] r_out;
  logic        r_out_en;
  logic        r_err_flag;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      r_out      <= '0;
      r_out_en   <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_out_en <= r_s1_vld;
      if (r_s1_vld) r_out <= w_load;
      // A clear wins over the old count but not over an error arriving in the same cycle.
      if (err_clr) begin
        r_err_flag <= w_err;
        r_err_cnt  <= w_err ? 8'd1 : 8'd0;
      end else if (w_err) begin
        r_err_flag <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign dataBusOut   = r_out;
  assign dataBusOutEn = r_out_en;
  assign err_flag     = r_err_flag;
  assign err_cnt      = r_err_cnt;
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed cases plus random traffic against a byte-level memory model.
module tb_data_bus_responder;
  logic        clk = 1'b0;
  logic        rstB;
  logic [31:0] addr, dataBusIn, periph_rdata;
  logic        wrEn, rdEn, err_clr;
  logic [3:0]  RamMode;
  logic [31:0] dataBusOut, periph_addr, periph_wdata;
  logic        dataBusOutEn, periph_wrEn, periph_rdEn, err_flag;
  logic [3:0]  periph_be;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  data_bus_responder dut (
    .clk(clk), .rstB(rstB), .addr(addr), .dataBusIn(dataBusIn), .wrEn(wrEn), .rdEn(rdEn),
    .RamMode(RamMode), .dataBusOut(dataBusOut), .dataBusOutEn(dataBusOutEn),
    .periph_addr(periph_addr), .periph_wdata(periph_wdata), .periph_be(periph_be),
    .periph_wrEn(periph_wrEn), .periph_rdEn(periph_rdEn), .periph_rdata(periph_rdata),
    .err_clr(err_clr), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  localparam logic [3:0] M_B = 4'b1000, M_BU = 4'b1001, M_H = 4'b0100, M_W = 4'b0010;

  int total = 0;
  int bad = 0;

  // Model state: RAM bytes 0..127, pending loads, expected registered outputs.
  typedef struct {
    int          due;
    bit          is_err;
    bit          is_periph;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] val;
  } rd_t;

  logic [7:0]  mem [128];
  rd_t         pend[$];
  int          cyc = 0;
  logic [31:0] exp_out = '0;
  bit          exp_en = 0;
  bit          exp_flag = 0;
  int          exp_cnt = 0;
  logic        cap_prd_en, cap_pwr_en;
  logic [3:0]  cap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int size_of(input logic [3:0] m);
    return m[3] ? 1 : (m[2] ? 2 : 4);
  endfunction

  function automatic int region(input logic [31:0] a);
    if ((a & 32'hF000_0000) == 32'h1000_0000) return 1;
    if ((a / 4) < 1024) return 0;
    return 2;
  endfunction

  function automatic bit bad_access(input logic [31:0] a, input logic [3:0] m);
    return ($countones(m[3:1]) != 1) || ((a % size_of(m)) != 0) || (region(a) == 2);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int sz, input bit uns);
    logic [31:0] v;
    if (sz == 1) begin
      v = raw & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = raw & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [3:0] m);
    if (size_of(m) == 1) return 4'(1 << (a % 4));
    if (size_of(m) == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [3:0] m);
    if (size_of(m) == 1) return {4{d[7:0]}};
    if (size_of(m) == 2) return {2{d[15:0]}};
    return d;
  endfunction

  // One request cycle: drive, check the combinational side, advance the model, check after the edge.
  task automatic step(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] prd, input bit clr);
    bit          bacc, err, do_rd;
    int          rg, sz;
    rd_t         r;
    logic [31:0] raw;
    wrEn = wr; rdEn = rd; addr = a; dataBusIn = d; RamMode = m; periph_rdata = prd; err_clr = clr;
    #1;
    bacc  = bad_access(a, m);
    rg    = region(a);
    sz    = size_of(m);
    do_rd = rd && !wr;
    cap_prd_en = periph_rdEn;
    cap_pwr_en = periph_wrEn;
    cap_be     = periph_be;
    chk("periph_rdEn", {31'b0, periph_rdEn}, {31'b0, do_rd && !bacc && rg == 1});
    chk("periph_wrEn", {31'b0, periph_wrEn}, {31'b0, wr && !bacc && rg == 1});
    chk("periph_addr", periph_addr, a);
    if (wr && !bacc && rg == 1) begin
      chk("periph_be", {28'b0, periph_be}, {28'b0, exp_be(a, m)});
      chk("periph_wdata", periph_wdata, exp_wdata(d, m));
    end

    exp_en = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      exp_en = 1;
      if (r.is_err) exp_out = '0;
      else if (r.is_periph) exp_out = extend(prd >> (8 * (r.a % 4)), size_of(r.m), r.m[0]);
      else exp_out = r.val;
    end
    if (do_rd) begin
      r.due = cyc + 1; r.is_err = bacc; r.is_periph = (rg == 1); r.a = a; r.m = m; r.val = '0;
      if (!bacc && rg == 0) begin
        raw = '0;
        for (int k = 0; k < sz; k++) raw = raw | (32'(mem[a + k]) << (8 * k));
        r.val = extend(raw, sz, m[0]);
      end
      pend.push_back(r);
    end
    if (wr && !bacc && rg == 0) begin
      for (int k = 0; k < sz; k++) mem[a + k] = d[8*k +: 8];
    end
    err = (wr || rd) && (bacc || (wr && rd));
    if (clr) begin
      exp_flag = err;
      exp_cnt  = err ? 1 : 0;
    end else if (err) begin
      exp_flag = 1;
      if (exp_cnt < 255) exp_cnt++;
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("dataBusOutEn", {31'b0, dataBusOutEn}, {31'b0, exp_en});
    chk("dataBusOut", dataBusOut, exp_out);
    chk("err_flag", {31'b0, err_flag}, {31'b0, exp_flag});
    chk("err_cnt", {24'b0, err_cnt}, 32'(exp_cnt));
  endtask

  task automatic idle(input logic [31:0] prd);
    step(0, 0, 32'h0, 32'h0, M_W, prd, 0);
  endtask

  task automatic random_phase(input int n);
    int          op, rsel, sz;
    bit          wr, rd, clr;
    logic [31:0] a;
    logic [3:0]  m;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      wr = (op < 3) || (op == 9);
      rd = (op >= 3 && op < 8) || (op == 9);
      if ($urandom_range(0, 9) == 0) m = 4'($urandom_range(0, 15));
      else m = {3'b001 << $urandom_range(0, 2), 1'($urandom_range(0, 1))};
      rsel = $urandom_range(0, 9);
      if (rsel < 6) a = 32'($urandom_range(0, 127));
      else if (rsel < 9) a = 32'h1000_0000 + 32'($urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 1) a = 32'h0000_1000 + 32'($urandom_range(0, 255));
      else a = 32'h8000_0000 + 32'($urandom_range(0, 255));
      sz = size_of(m);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      clr = ($urandom_range(0, 49) == 0);
      step(wr, rd, a, $urandom, m, $urandom, clr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstB = 0; wrEn = 0; rdEn = 0; addr = 0; dataBusIn = 0; RamMode = M_W;
    periph_rdata = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", dataBusOut, 32'h0);
    chk("rst_en", {31'b0, dataBusOutEn}, 32'h0);
    chk("rst_flag", {31'b0, err_flag}, 32'h0);
    chk("rst_cnt", {24'b0, err_cnt}, 32'h0);
    chk("rst_prd", {31'b0, periph_rdEn}, 32'h0);
    rstB = 1;

    for (int w = 0; w < 32; w++) step(1, 0, 32'(w * 4), $urandom, M_W, 32'h0, 0);

    // Store then immediate load of the same word.
    step(1, 0, 32'h40, 32'hDEADBEEF, M_W, 32'h0, 0);
    step(0, 1, 32'h40, 32'h0, M_W, 32'h0, 0);
    chk("t1_no_early_pulse", {31'b0, dataBusOutEn}, 32'h0);
    idle(32'h0);
    chk("t1_pulse", {31'b0, dataBusOutEn}, 32'h1);
    chk("t1_data", dataBusOut, 32'hDEADBEEF);

    // Back-to-back extended loads.
    step(0, 1, 32'h43, 32'h0, M_B, 32'h0, 0);
    step(0, 1, 32'h43, 32'h0, M_BU, 32'h0, 0);
    chk("t2_byte_s", dataBusOut, 32'hFFFFFFDE);
    step(0, 1, 32'h42, 32'h0, M_H, 32'h0, 0);
    chk("t2_byte_u", dataBusOut, 32'h000000DE);
    idle(32'h0);
    chk("t2_half_s", dataBusOut, 32'hFFFFDEAD);
    chk("t2_half_pulse", {31'b0, dataBusOutEn}, 32'h1);

    step(1, 0, 32'h41, 32'hABCDEF12, M_B, 32'h0, 0);
    step(0, 1, 32'h40, 32'h0, M_W, 32'h0, 0);
    idle(32'h0);
    chk("t3_lane1", dataBusOut, 32'hDEAD12EF);

    // Misaligned load, saturation, clear, clear colliding with an error.
    step(0, 1, 32'h42, 32'h0, M_W, 32'h0, 0);
    idle(32'h0);
    chk("t4_data0", dataBusOut, 32'h0);
    chk("t4_pulse", {31'b0, dataBusOutEn}, 32'h1);
    chk("t4_flag", {31'b0, err_flag}, 32'h1);
    chk("t4_cnt1", {24'b0, err_cnt}, 32'h1);
    for (int i = 0; i < 300; i++) step(1, 0, 32'h2001 + 32'(i), 32'h0, M_H, 32'h0, 0);
    chk("t4_cnt_sat", {24'b0, err_cnt}, 32'd255);
    step(0, 0, 32'h0, 32'h0, M_W, 32'h0, 1);
    chk("t4_clr_flag", {31'b0, err_flag}, 32'h0);
    chk("t4_clr_cnt", {24'b0, err_cnt}, 32'h0);
    step(1, 1, 32'h40, 32'h0, M_W, 32'h0, 1);
    chk("t4_clr_err_cnt", {24'b0, err_cnt}, 32'h1);
    step(0, 0, 32'h0, 32'h0, M_W, 32'h0, 1);

    // Peripheral load and half store.
    step(0, 1, 32'h1000_0008, 32'h0, M_W, $urandom, 0);
    chk("t5_rdEn_req", {31'b0, cap_prd_en}, 32'h1);
    idle(32'h0000_00A5);
    chk("t5_rdEn_after", {31'b0, cap_prd_en}, 32'h0);
    chk("t5_data", dataBusOut, 32'h0000_00A5);
    step(1, 0, 32'h1000_0006, 32'h0000_BEEF, M_H, 32'h0, 0);
    chk("t5_wrEn", {31'b0, cap_pwr_en}, 32'h1);
    chk("t5_be", {28'b0, cap_be}, 32'h0000_000C);

    // Reset with loads in flight.
    step(1, 0, 32'h40, 32'h0, 4'b0000, 32'h0, 0);
    step(0, 1, 32'h40, 32'h0, M_W, 32'h0, 0);
    rdEn = 1; wrEn = 0; addr = 32'h44; RamMode = M_W;
    #2;
    rstB = 0;
    #1;
    chk("t6_async_out", dataBusOut, 32'h0);
    chk("t6_async_flag", {31'b0, err_flag}, 32'h0);
    chk("t6_async_cnt", {24'b0, err_cnt}, 32'h0);
    chk("t6_async_prd", {31'b0, periph_rdEn}, 32'h0);
    @(posedge clk);
    #1;
    addr = 32'h48;
    chk("t6_rst_en", {31'b0, dataBusOutEn}, 32'h0);
    @(posedge clk);
    #1;
    rstB = 1;
    pend.delete();
    exp_out = '0; exp_en = 0; exp_flag = 0; exp_cnt = 0;
    cyc += 2;
    for (int i = 0; i < 4; i++) idle($urandom);
    chk("t6_out_zero", dataBusOut, 32'h0);

    random_phase(1500);
    repeat (3) idle($urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
